lcd_text_engine: RTL and testbench

Parametrised successor to the fixed-text LCD1602 controller.
- Drives an HD44780-compatible character LCD (1602/2004) in 8-bit mode from an internal, host-writable character buffer.
- Supports NUM_ROWS x NUM_COLS geometry, a refresh request/busy/done handshake, and per-cell writes at any time.
- Sits between application logic (sensor/pump status text) and the LCD pins in the top level.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_tick_gen.sv | 25 ++
 rtl/lcd_text_engine.sv | 182 ++++++++++++++++++
 tb/tb_lcd_text_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD text engine.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR,
        ST_FIN
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } lcd_phase_t;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_BLANK    = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // DDRAM start address of each display row (1602/2004 layout)
    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider: one-cycle tick every COUNT_MAX clk cycles.
module lcd_tick_gen #(
    parameter int unsigned COUNT_MAX = 800000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/lcd_text_engine.sv
// HD44780 8-bit text engine: init sequence, host-writable character buffer, full-screen refresh.
// Optional macro LCD_AUTO_REFRESH_EN adds a periodic refresh after REFRESH_TICKS idle ticks.
module lcd_text_engine
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_ROWS      = 2,
    parameter int unsigned NUM_COLS      = 16,
    parameter int unsigned COUNT_MAX     = 800000,
    parameter int unsigned REFRESH_TICKS = 64,
    localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          refresh_i,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [7:0]    wr_char,
    output logic          busy_o,
    output logic          done_o,
    output logic          init_done_o,
    output logic          rs,
    output logic          rw,
    output logic          enable,
    output logic [7:0]    data
);

    localparam logic [RW:0]   ROWS_L   = (RW+1)'(NUM_ROWS);
    localparam logic [CW:0]   COLS_L   = (CW+1)'(NUM_COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    lcd_state_t    state;
    lcd_phase_t    phase;
    logic [1:0]    init_idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          pending;
    logic          tick;
    logic          auto_req;
    logic          start_req;
    logic [7:0]    xfer_byte;
    logic [7:0]    buffer [NUM_ROWS][NUM_COLS];

    lcd_tick_gen #(.COUNT_MAX(COUNT_MAX)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rw = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    buffer[r][c] <= CHAR_BLANK;
                end
            end
        end else if (wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L)) begin
            buffer[wr_row][wr_col] <= wr_char;
        end
    end

`ifdef LCD_AUTO_REFRESH_EN
    localparam int unsigned TW = $clog2(REFRESH_TICKS + 1);
    localparam logic [TW-1:0] TICKS_L = TW'(REFRESH_TICKS);
    logic [TW-1:0] idle_ticks;

    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE && start_req)) begin
            idle_ticks <= '0;
        end else if (state == ST_IDLE && tick && idle_ticks != TICKS_L) begin
            idle_ticks <= idle_ticks + 1'b1;
        end
    end

    assign auto_req = (state == ST_IDLE) && (idle_ticks == TICKS_L);
`else
    assign auto_req = 1'b0;
`endif

    assign start_req = refresh_i | pending | auto_req;

    always_comb begin
        xfer_byte = '0;
        case (state)
            ST_INIT: xfer_byte = init_cmd(init_idx);
            ST_ADDR: xfer_byte = CMD_SET_DDRAM | row_base(2'(row));
            ST_CHAR: xfer_byte = buffer[row][col];
            default: xfer_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            phase       <= PH_SETUP;
            init_idx    <= '0;
            row         <= '0;
            col         <= '0;
            pending     <= 1'b0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            init_done_o <= 1'b0;
            rs          <= 1'b0;
            enable      <= 1'b0;
            data        <= '0;
        end else begin
            done_o <= 1'b0;
            if (state != ST_IDLE && refresh_i) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        busy_o  <= 1'b1;
                        pending <= 1'b0;
                        row     <= '0;
                        col     <= '0;
                        phase   <= PH_SETUP;
                        state   <= ST_ADDR;
                    end
                end
                ST_FIN: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    // INIT, ADDR and CHAR share one 3-tick transfer; step advance happens at HOLD
                    if (tick) begin
                        case (phase)
                            PH_SETUP: begin
                                rs    <= (state == ST_CHAR);
                                data  <= xfer_byte;
                                phase <= PH_PULSE;
                            end
                            PH_PULSE: begin
                                enable <= 1'b1;
                                phase  <= PH_HOLD;
                            end
                            default: begin
                                enable <= 1'b0;
                                phase  <= PH_SETUP;
                                case (state)
                                    ST_INIT: begin
                                        if (init_idx == 2'd3) begin
                                            init_done_o <= 1'b1;
                                            busy_o      <= 1'b0;
                                            state       <= ST_IDLE;
                                        end else begin
                                            init_idx <= init_idx + 1'b1;
                                        end
                                    end
                                    ST_ADDR: begin
                                        col   <= '0;
                                        state <= ST_CHAR;
                                    end
                                    default: begin
                                        if (col == LAST_COL) begin
                                            if (row == LAST_ROW) begin
                                                state <= ST_FIN;
                                            end else begin
                                                row   <= row + 1'b1;
                                                state <= ST_ADDR;
                                            end
                                        end else begin
                                            col <= col + 1'b1;
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_engine.sv
// Directed self-checking bench for lcd_text_engine: a 2x16 and a 4x20 instance, COUNT_MAX=4.
module tb_lcd_text_engine;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       refresh_a = 1'b0, wr_en_a = 1'b0;
    logic [0:0] wr_row_a = '0;
    logic [3:0] wr_col_a = '0;
    logic [7:0] wr_char_a = '0;
    logic       busy_a, done_a, init_a, rs_a, rw_a, en_a;
    logic [7:0] data_a;

    logic       refresh_b = 1'b0, wr_en_b = 1'b0;
    logic [1:0] wr_row_b = '0;
    logic [4:0] wr_col_b = '0;
    logic [7:0] wr_char_b = '0;
    logic       busy_b, done_b, init_b, rs_b, rw_b, en_b;
    logic [7:0] data_b;

    lcd_text_engine #(.NUM_ROWS(2), .NUM_COLS(16), .COUNT_MAX(4)) dut_a (
        .clk(clk), .reset(reset), .refresh_i(refresh_a), .wr_en(wr_en_a),
        .wr_row(wr_row_a), .wr_col(wr_col_a), .wr_char(wr_char_a),
        .busy_o(busy_a), .done_o(done_a), .init_done_o(init_a),
        .rs(rs_a), .rw(rw_a), .enable(en_a), .data(data_a)
    );

    lcd_text_engine #(.NUM_ROWS(4), .NUM_COLS(20), .COUNT_MAX(4)) dut_b (
        .clk(clk), .reset(reset), .refresh_i(refresh_b), .wr_en(wr_en_b),
        .wr_row(wr_row_b), .wr_col(wr_col_b), .wr_char(wr_char_b),
        .busy_o(busy_b), .done_o(done_b), .init_done_o(init_b),
        .rs(rs_b), .rw(rw_b), .enable(en_b), .data(data_b)
    );

    // Transfer log: {rs,data} captured at every rising edge of enable
    logic [8:0] log_a[$];
    logic [8:0] log_b[$];
    logic       en_a_q = 1'b0, en_b_q = 1'b0;
    int         done_a_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (en_a && !en_a_q) log_a.push_back({rs_a, data_a});
        if (en_b && !en_b_q) log_b.push_back({rs_b, data_b});
        en_a_q = en_a;
        en_b_q = en_b;
        if (done_a) done_a_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int entry_a(input int i);
        return (i < log_a.size()) ? int'(log_a[i]) : 'h1FF;
    endfunction

    function automatic int entry_b(input int i);
        return (i < log_b.size()) ? int'(log_b[i]) : 'h1FF;
    endfunction

    task automatic write_a(input int r, input int c, input logic [7:0] ch);
        wr_row_a = 1'(r); wr_col_a = 4'(c); wr_char_a = ch; wr_en_a = 1'b1;
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic write_b(input int r, input int c, input logic [7:0] ch);
        wr_row_b = 2'(r); wr_col_b = 5'(c); wr_char_b = ch; wr_en_b = 1'b1;
        @(negedge clk);
        wr_en_b = 1'b0;
    endtask

    task automatic wait_init_a(input int limit, output int cycles);
        cycles = 0;
        while (!init_a && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_done_a(input int limit, output int cycles);
        cycles = 0;
        while (!done_a && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulse_refresh_a();
        refresh_a = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
    endtask

    xfer_t exp_init [4];
    xfer_t exp_ref  [34];
    int    cyc;
    logic [7:0] row_cmd_b [4];

    initial begin
        exp_init[0] = '{1'b0, 8'h38};
        exp_init[1] = '{1'b0, 8'h0C};
        exp_init[2] = '{1'b0, 8'h01};
        exp_init[3] = '{1'b0, 8'h06};
        for (int i = 0; i < 34; i++) exp_ref[i] = '{1'b1, 8'h20};
        exp_ref[0]  = '{1'b0, 8'h80};
        exp_ref[1]  = '{1'b1, 8'h48};
        exp_ref[2]  = '{1'b1, 8'h49};
        exp_ref[17] = '{1'b0, 8'hC0};
        row_cmd_b[0] = 8'h80; row_cmd_b[1] = 8'hC0; row_cmd_b[2] = 8'h94; row_cmd_b[3] = 8'hD4;

        // 1: reset values and init sequence
        repeat (3) @(negedge clk);
        check("rst_rs", rs_a, 0);
        check("rst_rw", rw_a, 0);
        check("rst_enable", en_a, 0);
        check("rst_data", data_a, 0);
        check("rst_busy", busy_a, 1);
        check("rst_done", done_a, 0);
        check("rst_init_done", init_a, 0);
        reset = 1'b0;
        wait_init_a(200, cyc);
        check("init_cycles", cyc, 48);
        check("init_busy_low", busy_a, 0);
        check("init_b_done", init_b, 1);
        check("init_count", log_a.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("init_xfer%0d", i), entry_a(i), int'(exp_init[i]));

        // 2: 'H','I' then a full refresh of the 2x16 instance
        write_a(0, 0, 8'h48);
        write_a(0, 1, 8'h49);
        log_a.delete();
        done_a_cnt = 0;
        pulse_refresh_a();
        check("t2_busy_rise", busy_a, 1);
        wait_done_a(600, cyc);
        check("t2_done_seen", done_a, 1);
        check("t2_done_in_window", int'(cyc >= 406 && cyc <= 409), 1);
        check("t2_busy_fall", busy_a, 0);
        check("t2_xfer_count", log_a.size(), 34);
        for (int i = 0; i < 34; i++) check($sformatf("t2_xfer%0d", i), entry_a(i), int'(exp_ref[i]));
        repeat (20) @(negedge clk);
        check("t2_done_pulses", done_a_cnt, 1);

        // 3/4: 4x20 row addresses, last-column write kept, out-of-range columns dropped
        write_b(1, 19, 8'h5A);
        write_b(1, 20, 8'h58);
        write_b(1, 31, 8'h59);
        write_b(3, 25, 8'h58);
        log_b.delete();
        refresh_b = 1'b1;
        @(negedge clk);
        refresh_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        check("t3_done_seen", done_b, 1);
        check("t3_xfer_count", log_b.size(), 84);
        for (int r = 0; r < 4; r++) check($sformatf("t3_row_cmd%0d", r), entry_b(r * 21), int'({1'b0, row_cmd_b[r]}));
        for (int c = 0; c < 20; c++) check($sformatf("t4_row1_col%0d", c), entry_b(22 + c), (c == 19) ? 'h15A : 'h120);
        for (int c = 0; c < 20; c++) check($sformatf("t4_row3_col%0d", c), entry_b(64 + c), 'h120);

        // 5: two requests during a refresh collapse into one extra refresh; mid-refresh write lands
        log_a.delete();
        done_a_cnt = 0;
        pulse_refresh_a();
        repeat (40) @(negedge clk);
        pulse_refresh_a();
        write_a(1, 15, 8'h51);
        repeat (40) @(negedge clk);
        pulse_refresh_a();
        wait_done_a(600, cyc);
        check("t5_first_done", done_a, 1);
        check("t5_busy_at_done", busy_a, 0);
        @(negedge clk);
        check("t5_pending_busy", busy_a, 1);
        check("t5_done_one_clk", done_a, 0);
        wait_done_a(600, cyc);
        check("t5_second_done", done_a, 1);
        repeat (600) @(negedge clk);
        check("t5_done_pulses", done_a_cnt, 2);
        check("t5_idle_busy", busy_a, 0);
        check("t5_xfer_count", log_a.size(), 68);
        check("t5_late_write_seen", entry_a(33), 'h151);

        // 6: reset during CHAR phase, then init replays
        log_a.delete();
        pulse_refresh_a();
        repeat (30) @(negedge clk);
        check("t6_in_refresh", busy_a, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_enable", en_a, 0);
        check("t6_rst_data", data_a, 0);
        check("t6_rst_rs", rs_a, 0);
        check("t6_rst_busy", busy_a, 1);
        check("t6_rst_init_done", init_a, 0);
        reset = 1'b0;
        log_a.delete();
        wait_init_a(200, cyc);
        check("t6_init_cycles", cyc, 48);
        check("t6_init_count", log_a.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t6_init_xfer%0d", i), entry_a(i), int'(exp_init[i]));
        repeat (20) @(negedge clk);
        check("t6_no_stale_pending", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
